// File: rtl/simd_run_ctrl_if.sv
// simd_run_ctrl_if: PS command/status and datapath handshake bundle for simd_run_ctrl.
// master = PS/datapath side that issues commands and completion,
// slave  = the run controller itself.
interface simd_run_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 start;
  logic                 pause;
  logic                 abort;
  logic                 clear_done;
  logic [2:0]           ps_wr_en_in;
  logic [2:0]           bram_wr_en_out;
  logic                 dp_out_data_valid;
  logic                 dp_in_data_valid;
  logic                 dp_stall;
  logic                 dp_soft_rst;
  logic                 busy;
  logic                 done;
  logic                 err_timeout;
  logic                 wr_blocked;
  logic                 irq;
  logic [CNT_WIDTH-1:0] cycle_count;

  modport master (
    output start, pause, abort, clear_done, ps_wr_en_in, dp_out_data_valid,
    input  bram_wr_en_out, dp_in_data_valid, dp_stall, dp_soft_rst,
           busy, done, err_timeout, wr_blocked, irq, cycle_count
  );

  modport slave (
    input  start, pause, abort, clear_done, ps_wr_en_in, dp_out_data_valid,
    output bram_wr_en_out, dp_in_data_valid, dp_stall, dp_soft_rst,
           busy, done, err_timeout, wr_blocked, irq, cycle_count
  );
endinterface

// File: rtl/simd_run_ctrl.sv
// simd_run_ctrl: run controller between the PS register block and datapath_top.
// Launches a run with a one-cycle dp_in_data_valid, stalls the datapath while
// paused, detects completion on dp_out_data_valid, gates PS BRAM writes while
// busy and keeps busy/done/error status, a RUN-cycle counter and an irq pulse.
// Optional watchdog: define RUN_CTRL_WATCHDOG_EN to add the ERROR state, which
// is entered when a run spends TIMEOUT_CYCLES RUN cycles without completing.
module simd_run_ctrl #(
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           rst,
  simd_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
`ifdef RUN_CTRL_WATCHDOG_EN
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
`else
    ST_DONE   = 3'd4
`endif
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 wr_blocked_q, wr_blocked_d;
  logic                 irq_q, irq_d;
  logic                 in_valid_q, in_valid_d;
  logic                 stall_q, stall_d;
  logic                 soft_rst_q, soft_rst_d;
  logic                 was_busy;
  logic                 entering_done;
  logic                 entering_error;

`ifdef RUN_CTRL_WATCHDOG_EN
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic watchdog_hit;
  // The run has already spent TIMEOUT_CYCLES-1 RUN cycles, so this one is the last allowed
  assign watchdog_hit = (cycle_count_q == TIMEOUT_LAST);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: abort beats completion, completion beats timeout and pause
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (bus.abort) state_d = ST_IDLE;
        else           state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.abort)                  state_d = ST_IDLE;
        else if (bus.dp_out_data_valid) state_d = ST_DONE;
`ifdef RUN_CTRL_WATCHDOG_EN
        else if (watchdog_hit)          state_d = ST_ERROR;
`endif
        else if (bus.pause)             state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (bus.abort)                  state_d = ST_IDLE;
        else if (bus.dp_out_data_valid) state_d = ST_DONE;
        else if (!bus.pause)            state_d = ST_RUN;
      end
      ST_DONE: begin
        if (bus.start)           state_d = ST_LAUNCH;
        else if (bus.clear_done) state_d = ST_IDLE;
      end
`ifdef RUN_CTRL_WATCHDOG_EN
      ST_ERROR: begin
        if (bus.start)           state_d = ST_LAUNCH;
        else if (bus.clear_done) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every status output can be registered
  always_comb begin
    was_busy       = (state_q == ST_LAUNCH) || (state_q == ST_RUN) || (state_q == ST_PAUSED);
    entering_done  = (state_d == ST_DONE) && (state_q != ST_DONE);
`ifdef RUN_CTRL_WATCHDOG_EN
    entering_error = (state_d == ST_ERROR) && (state_q != ST_ERROR);
    err_timeout_d  = (state_d == ST_ERROR);
`else
    entering_error = 1'b0;
    err_timeout_d  = 1'b0;
`endif
    busy_d     = (state_d == ST_LAUNCH) || (state_d == ST_RUN) || (state_d == ST_PAUSED);
    in_valid_d = (state_d == ST_LAUNCH);
    stall_d    = (state_d == ST_PAUSED);
    done_d     = (state_d == ST_DONE);
    irq_d      = entering_done || entering_error;
    // A busy state only falls back to IDLE through abort
    soft_rst_d = (was_busy && (state_d == ST_IDLE)) || entering_error;

    cycle_count_d = cycle_count_q;
    if (state_d == ST_LAUNCH) begin
      cycle_count_d = '0;
    end else if ((state_q == ST_RUN) && (cycle_count_q != CNT_MAX)) begin
      cycle_count_d = cycle_count_q + 1'b1;
    end

    if (state_d == ST_LAUNCH) begin
      wr_blocked_d = 1'b0;
    end else begin
      wr_blocked_d = wr_blocked_q | (|(bus.ps_wr_en_in & {3{busy_q}}));
    end
  end

  // Registered status and datapath control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      wr_blocked_q  <= 1'b0;
      irq_q         <= 1'b0;
      in_valid_q    <= 1'b0;
      stall_q       <= 1'b0;
      soft_rst_q    <= 1'b0;
    end else begin
      cycle_count_q <= cycle_count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_timeout_q <= err_timeout_d;
      wr_blocked_q  <= wr_blocked_d;
      irq_q         <= irq_d;
      in_valid_q    <= in_valid_d;
      stall_q       <= stall_d;
      soft_rst_q    <= soft_rst_d;
    end
  end

  assign bus.bram_wr_en_out   = bus.ps_wr_en_in & {3{~busy_q}};
  assign bus.dp_in_data_valid = in_valid_q;
  assign bus.dp_stall         = stall_q;
  assign bus.dp_soft_rst      = soft_rst_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.err_timeout      = err_timeout_q;
  assign bus.wr_blocked       = wr_blocked_q;
  assign bus.irq              = irq_q;
  assign bus.cycle_count      = cycle_count_q;

endmodule

// File: tb/tb_simd_run_ctrl.sv
// tb_simd_run_ctrl: directed scenarios followed by random commands, checked
// against a run-level reference model and pulse scoreboards.
module tb_simd_run_ctrl;

  localparam int CNT_W   = 6;
  localparam int TO_CYC  = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  simd_run_ctrl_if #(.CNT_WIDTH(CNT_W)) rc_if ();

  simd_run_ctrl #(
    .CNT_WIDTH      (CNT_W),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (rc_if)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a run is either launching, active (optionally paused) or
  // not running; finished runs leave done/err flags behind
  bit m_launch, m_active, m_paused, m_done, m_err, m_wrblk;
  int m_count;
  int m_before;
  bit m_idle;

  // Scoreboards of pulses expected in the cycle following each edge
  int irq_cnt_q[$];
  bit irq_err_q[$];
  bit launch_q[$];
  bit srst_q[$];

  int stall_total  = 0;
  int irq_total    = 0;
  int srst_total   = 0;
  int launch_total = 0;

  bit pause_lvl;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit pa, input bit ab, input bit cd,
                               input bit dv, input logic [2:0] wr);
    @(posedge clk);
    #1;
    rc_if.start             = st;
    rc_if.pause             = pa;
    rc_if.abort             = ab;
    rc_if.clear_done        = cd;
    rc_if.dp_out_data_valid = dv;
    rc_if.ps_wr_en_in       = wr;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic sampleNow();
    @(negedge clk);
    #1;
  endtask

  // Reference model step on every edge, pushing the pulses this edge should cause
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_launch = 0; m_active = 0; m_paused = 0; m_done = 0; m_err = 0; m_wrblk = 0;
      m_count  = 0;
      irq_cnt_q.delete(); irq_err_q.delete(); launch_q.delete(); srst_q.delete();
    end else begin
      if ((m_launch || m_active) && (rc_if.ps_wr_en_in != 3'b000)) m_wrblk = 1;
      if (m_launch) begin
        m_launch = 0;
        if (rc_if.abort) srst_q.push_back(1'b1);
        else begin
          m_active = 1;
          m_paused = 0;
        end
      end else if (m_active) begin
        m_before = m_count;
        if (!m_paused && m_count < CNT_MAX) m_count = m_count + 1;
        if (rc_if.abort) begin
          m_active = 0; m_paused = 0;
          srst_q.push_back(1'b1);
        end else if (rc_if.dp_out_data_valid) begin
          m_active = 0; m_paused = 0; m_done = 1;
          irq_cnt_q.push_back(m_count);
          irq_err_q.push_back(1'b0);
        end
`ifdef RUN_CTRL_WATCHDOG_EN
        else if (!m_paused && m_before == TO_CYC - 1) begin
          m_active = 0; m_err = 1;
          irq_cnt_q.push_back(m_count);
          irq_err_q.push_back(1'b1);
          srst_q.push_back(1'b1);
        end
`endif
        else m_paused = rc_if.pause;
      end else begin
        m_idle = !m_done && !m_err;
        if (rc_if.start && !(m_idle && rc_if.abort)) begin
          m_launch = 1; m_done = 0; m_err = 0; m_count = 0; m_wrblk = 0;
          launch_q.push_back(1'b1);
        end else if (rc_if.clear_done) begin
          m_done = 0; m_err = 0;
        end
      end
    end
  end

  // Monitor: compare status against the model and match pulses to the scoreboards
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("busy", rc_if.busy, m_launch || m_active);
      checkOutput("dp_stall", rc_if.dp_stall, m_active && m_paused);
      checkOutput("done", rc_if.done, m_done);
      checkOutput("err_timeout", rc_if.err_timeout, m_err);
      checkOutput("wr_blocked", rc_if.wr_blocked, m_wrblk);
      checkOutput("cycle_count", rc_if.cycle_count, m_count);
      checkOutput("bram_wr_en_out", rc_if.bram_wr_en_out,
                  (m_launch || m_active) ? 3'b000 : rc_if.ps_wr_en_in);
      if (rc_if.dp_stall) stall_total++;
      if (rc_if.irq) begin
        irq_total++;
        checkOutput("irq expected", irq_cnt_q.size() != 0, 1);
        if (irq_cnt_q.size() != 0) begin
          checkOutput("irq cycle_count", rc_if.cycle_count, irq_cnt_q.pop_front());
          checkOutput("irq err_timeout", rc_if.err_timeout, irq_err_q.pop_front());
        end
      end
      if (rc_if.dp_in_data_valid) begin
        launch_total++;
        checkOutput("launch expected", launch_q.size() != 0, 1);
        if (launch_q.size() != 0) void'(launch_q.pop_front());
      end
      if (rc_if.dp_soft_rst) begin
        srst_total++;
        checkOutput("soft_rst expected", srst_q.size() != 0, 1);
        if (srst_q.size() != 0) void'(srst_q.pop_front());
      end
      checkOutput("irq missing", irq_cnt_q.size(), 0);
      checkOutput("launch missing", launch_q.size(), 0);
      checkOutput("soft_rst missing", srst_q.size(), 0);
      irq_cnt_q.delete(); irq_err_q.delete(); launch_q.delete(); srst_q.delete();
    end
  end

  // Hard time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 2000000");
    $fatal(1, "[TB] time limit reached");
  end

  // Directed scenarios followed by random command traffic
  initial begin
    int snap_a, snap_b, snap_c;
    rc_if.start = 0; rc_if.pause = 0; rc_if.abort = 0; rc_if.clear_done = 0;
    rc_if.dp_out_data_valid = 0; rc_if.ps_wr_en_in = 3'b101;
    pause_lvl = 0;
    rst = 1'b1;

    sampleNow();
    checkOutput("reset busy", rc_if.busy, 0);
    checkOutput("reset cycle_count", rc_if.cycle_count, 0);
    checkOutput("reset irq", rc_if.irq, 0);
    checkOutput("reset dp_stall", rc_if.dp_stall, 0);
    checkOutput("reset done", rc_if.done, 0);
    checkOutput("reset bram passthrough", rc_if.bram_wr_en_out, 3'b101);
    rst = 1'b0;
    rc_if.ps_wr_en_in = 3'b000;

    // Basic run: completion after 10 RUN cycles
    snap_a = irq_total;
    applyStimulus(1, 0, 0, 0, 0, 3'b000);
    idleCycles(1);
    sampleNow();
    checkOutput("t+1 dp_in_data_valid", rc_if.dp_in_data_valid, 1);
    checkOutput("t+1 busy", rc_if.busy, 1);
    idleCycles(9);
    applyStimulus(0, 0, 0, 0, 1, 3'b000);
    idleCycles(1);
    sampleNow();
    checkOutput("run done", rc_if.done, 1);
    checkOutput("run irq", rc_if.irq, 1);
    checkOutput("run busy", rc_if.busy, 0);
    checkOutput("run cycle_count", rc_if.cycle_count, 10);
    idleCycles(2);
    sampleNow();
    checkOutput("run irq pulses", irq_total - snap_a, 1);

    // Pause for 5 cycles inside a 10 RUN-cycle run, started from DONE
    snap_a = stall_total;
    applyStimulus(1, 0, 0, 0, 0, 3'b000);
    idleCycles(4);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0, 3'b000);
    idleCycles(6);
    applyStimulus(0, 0, 0, 0, 1, 3'b000);
    idleCycles(1);
    sampleNow();
    checkOutput("pause stall cycles", stall_total - snap_a, 5);
    checkOutput("pause cycle_count", rc_if.cycle_count, 10);

    // Start from DONE clears status at t+1; start while running is ignored
    snap_a = launch_total;
    applyStimulus(1, 0, 0, 0, 0, 3'b000);
    idleCycles(1);
    sampleNow();
    checkOutput("restart done cleared", rc_if.done, 0);
    checkOutput("restart count cleared", rc_if.cycle_count, 0);
    idleCycles(2);
    applyStimulus(1, 0, 0, 0, 0, 3'b000);
    idleCycles(3);
    applyStimulus(0, 0, 0, 0, 1, 3'b000);
    idleCycles(1);
    sampleNow();
    checkOutput("restart launches", launch_total - snap_a, 1);
    checkOutput("restart done", rc_if.done, 1);

    // Abort together with completion, with a blocked write during the run
    applyStimulus(0, 0, 0, 1, 0, 3'b000);
    idleCycles(1);
    snap_a = irq_total;
    snap_b = srst_total;
    applyStimulus(1, 0, 0, 0, 0, 3'b000);
    idleCycles(2);
    applyStimulus(0, 0, 0, 0, 0, 3'b101);
    sampleNow();
    checkOutput("busy bram gated", rc_if.bram_wr_en_out, 3'b000);
    idleCycles(1);
    applyStimulus(0, 0, 1, 0, 1, 3'b000);
    idleCycles(1);
    sampleNow();
    checkOutput("abort busy", rc_if.busy, 0);
    checkOutput("abort done", rc_if.done, 0);
    checkOutput("abort irq pulses", irq_total - snap_a, 0);
    checkOutput("abort soft_rst pulses", srst_total - snap_b, 1);
    checkOutput("abort wr_blocked", rc_if.wr_blocked, 1);
    applyStimulus(0, 0, 0, 0, 0, 3'b101);
    sampleNow();
    checkOutput("idle bram passthrough", rc_if.bram_wr_en_out, 3'b101);
    idleCycles(1);

`ifdef RUN_CTRL_WATCHDOG_EN
    // Watchdog: no completion, ERROR after TO_CYC RUN cycles
    snap_b = srst_total;
    applyStimulus(1, 0, 0, 0, 0, 3'b000);
    idleCycles(1 + TO_CYC);
    idleCycles(1);
    sampleNow();
    checkOutput("wd err_timeout", rc_if.err_timeout, 1);
    checkOutput("wd irq", rc_if.irq, 1);
    checkOutput("wd cycle_count", rc_if.cycle_count, TO_CYC);
    checkOutput("wd soft_rst pulses", srst_total - snap_b, 1);
    applyStimulus(0, 0, 0, 1, 0, 3'b000);
    idleCycles(1);
    sampleNow();
    checkOutput("wd cleared err", rc_if.err_timeout, 0);
    checkOutput("wd cleared busy", rc_if.busy, 0);
`else
    // Long run: counter saturates at all-ones
    applyStimulus(1, 0, 0, 0, 0, 3'b000);
    idleCycles(71);
    sampleNow();
    checkOutput("saturated count", rc_if.cycle_count, CNT_MAX);
    checkOutput("no err_timeout", rc_if.err_timeout, 0);
    applyStimulus(0, 0, 0, 0, 1, 3'b000);
    idleCycles(1);
    sampleNow();
    checkOutput("saturated done count", rc_if.cycle_count, CNT_MAX);
    applyStimulus(0, 0, 0, 1, 0, 3'b000);
`endif

    // Asynchronous reset in the middle of a run
    snap_c = srst_total;
    applyStimulus(1, 0, 0, 0, 0, 3'b000);
    idleCycles(1);
    applyStimulus(0, 0, 0, 0, 0, 3'b011);
    idleCycles(2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("mid reset busy", rc_if.busy, 0);
    checkOutput("mid reset cycle_count", rc_if.cycle_count, 0);
    checkOutput("mid reset wr_blocked", rc_if.wr_blocked, 0);
    checkOutput("mid reset soft_rst", rc_if.dp_soft_rst, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    idleCycles(3);
    sampleNow();
    checkOutput("mid reset no soft_rst", srst_total - snap_c, 0);

    // Random command traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) pause_lvl = ~pause_lvl;
      applyStimulus($urandom_range(0, 7) == 0, pause_lvl,
                    $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 11) == 0,
                    ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
    end
    idleCycles(4);
    sampleNow();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/simd_run_ctrl.md
# simd_run_ctrl

Run controller for the SIMD datapath. Accepts start/pause/abort commands from the PS, launches execution with a one-cycle `in_data_valid`, holds `stall` while paused, and detects completion on `out_data_valid`. While a program runs, it blocks PS writes into the A/B/INS BRAMs. It also reports busy/done/error status, a cycle count and a completion interrupt. It sits between the PS register interface and `datapath_top`.

## Interface

Parameters:
- `CNT_WIDTH`, 32: width of the run-cycle counter.
- `TIMEOUT_CYCLES`, 1000000: watchdog limit in RUN cycles. Used only with `RUN_CTRL_WATCHDOG_EN`.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a run.
- `pause`  in  1  level; requests that the datapath be held stalled.
- `abort`  in  1  one-cycle pulse; kills the current run.
- `clear_done`  in  1  one-cycle pulse; returns DONE/ERROR to IDLE.
- `ps_wr_en_in`  in  3  PS write enables: bit0 A, bit1 B, bit2 INS.
- `bram_wr_en_out`  out  3  gated write enables to `datapath_top`.
- `dp_out_data_valid`  in  1  completion pulse from the datapath.
- `dp_in_data_valid`  out  1  launch pulse to the datapath.
- `dp_stall`  out  1  stall to the datapath.
- `dp_soft_rst`  out  1  one-cycle datapath reset request.
- `busy`  out  1  high in LAUNCH, RUN and PAUSED.
- `done`  out  1  sticky; high in DONE.
- `err_timeout`  out  1  sticky; high in ERROR.
- `wr_blocked`  out  1  sticky; a PS write was suppressed.
- `irq`  out  1  one-cycle completion/error pulse.
- `cycle_count`  out  `CNT_WIDTH`  RUN-state cycles of the current or last run.

## Operation

- States: IDLE, LAUNCH, RUN, PAUSED, DONE, ERROR. ERROR exists only with the watchdog compiled in.
- IDLE or DONE, on `start`:
  - go to LAUNCH;
  - clear `cycle_count`, `done`, `wr_blocked`.
- LAUNCH: `dp_in_data_valid`=1 for exactly this cycle, then RUN.
- RUN:
  - `cycle_count` increments each cycle and saturates at all-ones.
  - `pause`=1 → PAUSED.
  - `dp_out_data_valid` → DONE.
- PAUSED:
  - `dp_stall`=1 and the counter holds.
  - `pause`=0 → RUN.
  - `dp_out_data_valid` is still honoured → DONE.
- DONE: `done`=1. Exits on `clear_done` → IDLE, or `start` → LAUNCH.
- `abort` in LAUNCH/RUN/PAUSED:
  - → IDLE with `dp_soft_rst` pulsed;
  - no `irq`; `done` stays 0.
  - In IDLE/DONE/ERROR, `abort` is ignored.
- Priority within a cycle: `abort` > `dp_out_data_valid` > `pause`. In IDLE, `abort` with `start` → start ignored.
- `start` while busy is ignored.
- `clear_done` outside DONE/ERROR is ignored.
- `dp_out_data_valid` outside RUN/PAUSED is ignored.
- `irq` pulses for one cycle on entry to DONE or ERROR.
- Write gating (combinational): `bram_wr_en_out = ps_wr_en_in & {3{~busy}}`. Any suppressed bit sets `wr_blocked` on the next edge.

## Timing

- Reset (asynchronous):
  - state IDLE;
  - every registered output 0 (`cycle_count`=0, `dp_stall`=0, `irq`=0);
  - `bram_wr_en_out` follows `ps_wr_en_in` because `busy`=0.
- Reset mid-run: immediate return to IDLE with all status cleared; no `dp_soft_rst` issued.
- Handshake latencies, relative to a `start` sampled at edge t:
  - `busy` and `dp_in_data_valid` are high during cycle t+1;
  - RUN begins at t+2.
- `dp_out_data_valid` sampled at edge u: `done`=1, `irq`=1 and `busy`=0 in cycle u+1.
- `pause` sampled at edge p: `dp_stall`=1 from cycle p+1. Release has the same latency.
- `cycle_count` in DONE equals the number of RUN cycles. PAUSED and LAUNCH cycles are excluded.
- All outputs except `bram_wr_en_out` are registered.

## Configuration

- `RUN_CTRL_WATCHDOG_EN` defined:
  - A RUN cycle in which `cycle_count` reaches `TIMEOUT_CYCLES-1` with no `dp_out_data_valid` → ERROR.
  - On entry to ERROR: `err_timeout`=1 and `dp_soft_rst`, `irq` pulse.
  - ERROR exits as DONE does.
  - `dp_out_data_valid` in that same cycle wins (DONE).
- Not defined: no ERROR state, `err_timeout` tied 0, no timeout.

## Test plan

- Reset, then `start`; `dp_out_data_valid` after 10 RUN cycles → `dp_in_data_valid` single pulse at t+1, `done`=1, `irq` one pulse, `cycle_count`=10.
- Run with `pause` high for 5 cycles mid-run, total 10 RUN cycles → `dp_stall` high exactly 5 cycles, `cycle_count`=10.
- `abort` in RUN, same cycle as `dp_out_data_valid` → IDLE, `dp_soft_rst` one pulse, `done`=0, `irq`=0.
- `ps_wr_en_in`=3'b101 while busy → `bram_wr_en_out`=0, `wr_blocked`=1. In IDLE the same input passes through as 3'b101.
- Watchdog, `TIMEOUT_CYCLES`=16, no completion → ERROR after 16 RUN cycles, `err_timeout`=1, `irq`/`dp_soft_rst` pulse. `clear_done` → IDLE.
- `start` in DONE → new run, `done` and `cycle_count` cleared at t+1. `start` while RUN → ignored.
